// File: rtl/regfile_multiport.sv
// Parametrised multi-read-port register file for the decode stage.
// Register 0 is hardwired to zero, the single write port has byte-lane
// enables, and a clearing sequencer zeroes every entry after reset before
// ready is raised.
// Optional feature: define REGFILE_BYPASS_EN to forward the write port to
// any read port addressing the same register in the same cycle.
module regfile_multiport #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_READ = 2,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [NUM_READ*ADDR_W-1:0]   rr,
  output logic [NUM_READ*WIDTH-1:0]    readData,
  input  logic [ADDR_W-1:0]            wr,
  input  logic [WIDTH-1:0]             writeData,
  input  logic                         writeEN,
  input  logic [WIDTH/8-1:0]           writeBE,
  output logic                         ready
);

  localparam int NUM_BYTES = WIDTH / 8;

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e                 state_q;
  logic [ADDR_W-1:0]      clr_ptr_q;
  logic [WIDTH-1:0]       regs_q [DEPTH];

  logic                   wr_live;

  // A write only takes effect in IDLE and never to the zero register.
  assign wr_live = (state_q == StIdle) && writeEN && (wr != '0);

  // Sequencer, clear pointer, ready flag and register array updates.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= StClear;
      clr_ptr_q <= '0;
      ready     <= 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          regs_q[clr_ptr_q] <= '0;
          if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= StIdle;
            ready   <= 1'b1;
          end else begin
            clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
          end
        end
        StIdle: begin
          if (wr_live) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
              if (writeBE[b]) begin
                regs_q[wr][8*b +: 8] <= writeData[8*b +: 8];
              end
            end
          end
        end
        default: begin
          state_q <= StClear;
        end
      endcase
    end
  end

  // Combinational read ports; forced to zero while clearing or for address 0.
  always_comb begin
    readData = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      if ((state_q == StIdle) && (rr[k*ADDR_W +: ADDR_W] != '0)) begin
        readData[k*WIDTH +: WIDTH] = regs_q[rr[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
        // Forward enabled lanes of an in-flight write to a matching port.
        if (wr_live && (rr[k*ADDR_W +: ADDR_W] == wr)) begin
          for (int b = 0; b < NUM_BYTES; b++) begin
            if (writeBE[b]) begin
              readData[k*WIDTH + 8*b +: 8] = writeData[8*b +: 8];
            end
          end
        end
`else
        // No forwarding: a same-cycle read returns the stored value.
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed self-checking bench for regfile_multiport (WIDTH=32, DEPTH=32,
// NUM_READ=2). Expectations for the same-cycle hazard follow
// REGFILE_BYPASS_EN.
module tb_regfile_multiport;

  localparam int WIDTH    = 32;
  localparam int DEPTH    = 32;
  localparam int NUM_READ = 2;
  localparam int ADDR_W   = 5;

  logic                       Clk;
  logic                       Rst;
  logic [NUM_READ*ADDR_W-1:0] rr;
  logic [NUM_READ*WIDTH-1:0]  readData;
  logic [ADDR_W-1:0]          wr;
  logic [WIDTH-1:0]           writeData;
  logic                       writeEN;
  logic [WIDTH/8-1:0]         writeBE;
  logic                       ready;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_multiport #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .NUM_READ (NUM_READ)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .rr        (rr),
    .readData  (readData),
    .wr        (wr),
    .writeData (writeData),
    .writeEN   (writeEN),
    .writeBE   (writeBE),
    .ready     (ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance past one rising edge; inputs driven afterwards settle before the next.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr = a; writeData = d; writeBE = be; writeEN = 1'b1;
    step();
    writeEN = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    rr = {5'd17, 5'd4};
    #1;
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0", ready);
    end
    n_checks++;
    if (readData !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", readData);
    end
    Rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rr = {5'(i), 5'(31 - i)};
      #1;
      n_checks++;
      if (ready !== 1'b0 || readData !== '0) begin
        n_fail++;
        $display("FAIL clear_cycle_%0d: ready=%b data=%h want ready=0 data=0", i, ready, readData);
      end
      step();
    end
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++; $display("FAIL clear_done_ready: got %b want 1", ready);
    end
    for (int a = 0; a < DEPTH; a++) begin
      rr = {5'(a), 5'(a)};
      #1;
      n_checks++;
      if (readData !== '0) begin
        n_fail++; $display("FAIL cleared_addr_%0d: got %h want 0", a, readData);
      end
    end
  endtask

  task automatic test_basic();
    do_write(5'd3, 32'hFFFFFEA8, 4'hF);
    rr = {5'd5, 5'd3};
    #1;
    n_checks++;
    if (readData[31:0] !== 32'hFFFFFEA8) begin
      n_fail++; $display("FAIL basic_port0: got %h want FFFFFEA8", readData[31:0]);
    end
    n_checks++;
    if (readData[63:32] !== 32'h0) begin
      n_fail++; $display("FAIL basic_port1: got %h want 00000000", readData[63:32]);
    end
  endtask

  task automatic test_byte_enable();
    do_write(5'd7, 32'h11223344, 4'hF);
    do_write(5'd7, 32'hAABBCCDD, 4'b0101);
    rr = {5'd7, 5'd7};
    #1;
    n_checks++;
    if (readData !== {32'h11BB33DD, 32'h11BB33DD}) begin
      n_fail++; $display("FAIL byte_enable: got %h want 11BB33DD on both ports", readData);
    end
  endtask

  task automatic test_zero_reg();
    do_write(5'd0, 32'hDEADBEEF, 4'hF);
    rr = {5'd0, 5'd0};
    #1;
    n_checks++;
    if (readData !== '0) begin
      n_fail++; $display("FAIL zero_reg: got %h want 0", readData);
    end
    rr = {5'd7, 5'd3};
    #1;
    n_checks++;
    if (readData !== {32'h11BB33DD, 32'hFFFFFEA8}) begin
      n_fail++; $display("FAIL zero_reg_side_effect: got %h want 11BB33DDFFFFFEA8", readData);
    end
  endtask

  task automatic test_hazard();
    logic [31:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
    exp_pre = 32'h5A5A5A5A;
`else
    exp_pre = 32'h0;
`endif
    rr = {5'd9, 5'd3};
    wr = 5'd9; writeData = 32'h5A5A5A5A; writeBE = 4'hF; writeEN = 1'b1;
    #1;
    n_checks++;
    if (readData[63:32] !== exp_pre) begin
      n_fail++; $display("FAIL hazard_pre_edge: got %h want %h", readData[63:32], exp_pre);
    end
    n_checks++;
    if (readData[31:0] !== 32'hFFFFFEA8) begin
      n_fail++; $display("FAIL hazard_other_port: got %h want FFFFFEA8", readData[31:0]);
    end
    step();
    writeEN = 1'b0;
    #1;
    n_checks++;
    if (readData[63:32] !== 32'h5A5A5A5A) begin
      n_fail++; $display("FAIL hazard_post_edge: got %h want 5A5A5A5A", readData[63:32]);
    end
  endtask

  task automatic test_reset_mid_clear();
    // Reset from IDLE drops ready on the next edge.
    Rst = 1'b1;
    step();
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++; $display("FAIL idle_reset_ready: got %b want 0", ready);
    end
    Rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    wr = 5'd4; writeData = 32'h12345678; writeBE = 4'hF; writeEN = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (ready !== 1'b0) begin
        n_fail++; $display("FAIL restart_cycle_%0d: ready=%b want 0", i, ready);
      end
      step();
    end
    writeEN = 1'b0;
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++; $display("FAIL restart_done_ready: got %b want 1", ready);
    end
    rr = {5'd3, 5'd4};
    #1;
    n_checks++;
    if (readData !== '0) begin
      n_fail++; $display("FAIL clear_write_lost: got %h want 0 (reg3,reg4)", readData);
    end
  endtask

  initial begin
    Rst = 1'b1; rr = '0; wr = '0; writeData = '0; writeEN = 1'b0; writeBE = '0;
    test_reset();
    test_basic();
    test_byte_enable();
    test_zero_reg();
    test_hazard();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised, multi-read-port register file for the MIPS datapath; the successor to the fixed 32x32, two-read-port file. It adds configurable width, depth and read-port count, a hardwired zero register, byte-lane write enables, and a post-reset clearing sequencer that zeroes every entry before the file reports ready. Instantiated in the decode stage; write-back drives the single write port.

## Interface
- WIDTH, 32: data width in bits; multiple of 8.
- DEPTH, 32: number of registers; power of two, at least 2.
- NUM_READ, 2: number of read ports, 1..4.
- ADDR_W, $clog2(DEPTH): address width; derived, never overridden.
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  synchronous, active-high reset.
- rr  input  NUM_READ*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- readData  output  NUM_READ*WIDTH  packed read data; port k uses bits [k*WIDTH +: WIDTH].
- wr  input  ADDR_W  write address.
- writeData  input  WIDTH  write data.
- writeEN  input  1  write enable.
- writeBE  input  WIDTH/8  byte-lane enables; bit b gates writeData[8b+7:8b].
- ready  output  1  high once the clearing sequence has completed.

## Operation
- States: CLEAR, IDLE. Rst high forces CLEAR with clear pointer clrPtr = 0 and ready = 0, regardless of current state.
- CLEAR with Rst low: each cycle writes 0 to registers[clrPtr] and increments clrPtr. The cycle with clrPtr == DEPTH-1 transitions to IDLE. clrPtr does not wrap.
- IDLE: if writeEN == 1 and wr != 0, then for each b with writeBE[b] == 1, registers[wr] byte b takes writeData byte b. Unselected bytes hold their value.
- Register 0 always reads 0. Writes to address 0 are discarded with no side effect.
- Reads are combinational. readData port k = registers[rr port k].
- In CLEAR, all readData ports are forced to 0 and writeEN is ignored. Writes presented during CLEAR are lost, not queued.
- Multiple read ports may address the same register. Each port returns the same value independently.
- Out-of-range addresses cannot occur because DEPTH = 2^ADDR_W.

## Timing
- Reset values: ready = 0, every readData = 0, state = CLEAR, clrPtr = 0. Register contents are unspecified until cleared.
- Clear latency: ready rises after the DEPTH-th rising edge following the first edge with Rst low, i.e. exactly DEPTH cycles.
- Rst asserted mid-CLEAR restarts the sequence at clrPtr = 0. Rst asserted in IDLE drops ready on the next edge and the full clear is re-run.
- Write latency: data sampled at a rising edge with writeEN = 1 is stored by that edge. Without bypass, it is visible on readData after that edge.
- Writes occur on the rising edge, not the falling edge. Upstream must therefore hold wr, writeData, writeEN and writeBE stable across the rising edge.
- Simultaneous write and read of the same address: behaviour is defined by the macro below.

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read forwarding is enabled. When state is IDLE, writeEN = 1, wr != 0 and rr port k == wr, readData port k equals writeData in enabled byte lanes and the stored bytes in disabled lanes, in the same cycle (combinational path from writeData to readData).
- REGFILE_BYPASS_EN undefined: no forwarding. A same-cycle read returns the pre-write value, and the new value appears after the edge. The hazard unit must stall one cycle.

## Test plan
- Reset and clear: hold Rst for 3 cycles, then release, with DEPTH = 32. Required: ready = 0 for 32 cycles and rises after the 32nd edge; all readData = 0 throughout; afterwards every address reads 0.
- Basic write/read with NUM_READ = 2: in IDLE, write wr = 3, writeData = 0xFFFFFEA8 (-344), writeBE = 4'hF. Then set rr = {5, 3}. Required: port 0 reads 0xFFFFFEA8, port 1 reads 0.
- Byte enables: register 7 holds 0x11223344; write 0xAABBCCDD with writeBE = 4'b0101. Required: register 7 reads 0x11BB33DD.
- Zero register: write wr = 0, writeData = 0xDEADBEEF. Required: rr = 0 reads 0; no other register changes.
- Same-cycle hazard: write wr = 9, writeData = 0x5A5A5A5A while rr port 1 = 9 and the old value is 0. Required: with REGFILE_BYPASS_EN, port 1 reads 0x5A5A5A5A before the edge; without it, port 1 reads 0 before the edge and 0x5A5A5A5A after.
- Reset mid-clear and writes during CLEAR: assert Rst at clear cycle 10 and attempt writeEN = 1 to wr = 4 during CLEAR. Required: clear restarts and ready rises 32 cycles after the second release; register 4 reads 0.
